// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency byte-addressed data memory responder, big-endian
module dmem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [3:0]  req_size,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic          cap_write;
   logic [63:0]   cap_addr;
   logic [63:0]   cap_wdata;
   logic [3:0]    cap_size;

   logic [7:0]    mem [DEPTH] = '{default: 8'h00};

   logic          size_ok;
   logic          aligned;
   logic          in_range;
   logic          legal;
   logic [AW-1:0] base;
   logic [63:0]   rd_val;
   logic [63:0]   wleft;
   logic          do_store;

   always_comb begin
      size_ok  = (cap_size == 4'd1) || (cap_size == 4'd2) ||
                 (cap_size == 4'd4) || (cap_size == 4'd8);
      aligned  = (cap_addr[3:0] & (cap_size - 4'd1)) == 4'd0;
      // 65-bit sum so addresses near 2^64 cannot wrap into range
      in_range = ({1'b0, cap_addr} + {61'd0, cap_size}) <= 65'(DEPTH);
      legal    = size_ok && aligned && in_range;
      base     = cap_addr[AW-1:0];
      rd_val   = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < int'(cap_size)) rd_val = {rd_val[55:0], mem[base + AW'(i)]};
      end
      // Left-justify store data so byte i of the field sits at bits [63-8i -: 8]
      wleft    = cap_wdata << {(4'd8 - cap_size), 3'b000};
      do_store = reset && (state == WAIT) && (count == '0) && cap_write && legal;
   end

   always_ff @(posedge clk) begin
      if (do_store) begin
         for (int i = 0; i < 8; i++) begin
            if (i < int'(cap_size)) mem[base + AW'(i)] <= wleft[63-8*i -: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         count     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cap_write <= req_write;
                  cap_addr  <= req_addr;
                  cap_wdata <= req_wdata;
                  cap_size  <= req_size;
                  count     <= CW'(LATENCY - 1);
                  req_ready <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (count == '0) begin
                  rsp_rdata <= (legal && !cap_write) ? rd_val : 64'd0;
                  rsp_err   <= !legal;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  count <= count - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed checks of dmem_responder with DEPTH=1024, LATENCY=3
module tb_dmem_responder;

   localparam int DEPTH = 1024;
   localparam int LAT   = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [3:0]  req_size;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_rdata;
   logic        rsp_err;

   int total = 0;
   int bad   = 0;

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Issue one request with rsp_ready held high; checks latency, data, error and idle return
   task automatic txn(input string tag, input logic w, input logic [63:0] a, input logic [63:0] d,
                      input logic [3:0] s, input logic [63:0] exp_rd, input logic exp_err);
      int n;
      int lat;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_size = s;
      rsp_ready = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_accept"}, 64'(n < 20), 64'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_write = ~w; req_addr = 64'h10; req_wdata = 64'h5A5A5A5A5A5A5A5A; req_size = 4'd8;
      lat = 0;
      forever begin
         @(negedge clk);
         if (rsp_valid || lat >= 20) break;
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(LAT));
      chk({tag, "_rdata"}, rsp_rdata, exp_rd);
      chk({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
      @(negedge clk);
      chk({tag, "_idle"}, {62'd0, rsp_valid, req_ready}, 64'b01);
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
      req_wdata = '0; req_size = 4'd1; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rdata", rsp_rdata, 64'd0);
      chk("rst_err", 64'(rsp_err), 64'd0);

      txn("ld0", 1'b0, 64'd0, 64'd0, 4'd8, 64'd0, 1'b0);
      txn("st16", 1'b1, 64'd16, 64'h0123456789ABCDEF, 4'd8, 64'd0, 1'b0);
      txn("ld16_8", 1'b0, 64'd16, 64'd0, 4'd8, 64'h0123456789ABCDEF, 1'b0);
      txn("ld16_1", 1'b0, 64'd16, 64'd0, 4'd1, 64'h01, 1'b0);
      txn("ld22_2", 1'b0, 64'd22, 64'd0, 4'd2, 64'hCDEF, 1'b0);
      txn("st20_4", 1'b1, 64'd20, 64'hFFFFFFFFDEADBEEF, 4'd4, 64'd0, 1'b0);
      txn("ld16_p", 1'b0, 64'd16, 64'd0, 4'd8, 64'h01234567DEADBEEF, 1'b0);
      txn("ld_top", 1'b0, 64'(DEPTH - 8), 64'd0, 4'd8, 64'd0, 1'b0);

      txn("e_misal", 1'b1, 64'd18, 64'h1111111111111111, 4'd4, 64'd0, 1'b1);
      txn("e_misal_ck", 1'b0, 64'd16, 64'd0, 4'd8, 64'h01234567DEADBEEF, 1'b0);
      txn("e_size3", 1'b1, 64'd0, 64'h2222222222222222, 4'd3, 64'd0, 1'b1);
      txn("e_size3_ck", 1'b0, 64'd0, 64'd0, 4'd8, 64'd0, 1'b0);
      txn("e_oor", 1'b0, 64'(DEPTH - 4), 64'd0, 4'd8, 64'd0, 1'b1);
      txn("e_wrap", 1'b1, 64'hFFFFFFFFFFFFFFF8, 64'h3333333333333333, 4'd8, 64'd0, 1'b1);
      txn("e_wrap_ck", 1'b0, 64'd16, 64'd0, 4'd8, 64'h01234567DEADBEEF, 1'b0);
      txn("e_wrap_ck0", 1'b0, 64'd0, 64'd0, 4'd8, 64'd0, 1'b0);

      // Backpressure: response held 5 cycles, a stray store request must be ignored
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 64'd16; req_size = 4'd8; rsp_ready = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (LAT) @(posedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         req_valid = (k == 2); req_write = 1'b1; req_addr = 64'd16; req_wdata = 64'hBAD0BAD0BAD0BAD0;
         chk("bp_valid", 64'(rsp_valid), 64'd1);
         chk("bp_rdata", rsp_rdata, 64'h01234567DEADBEEF);
         chk("bp_req_ready", 64'(req_ready), 64'd0);
      end
      @(negedge clk);
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp_after", {62'd0, rsp_valid, req_ready}, 64'b01);
      txn("bp_ck", 1'b0, 64'd16, 64'd0, 4'd8, 64'h01234567DEADBEEF, 1'b0);

      // Reset during WAIT abandons the store
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd40; req_wdata = 64'hAA; req_size = 4'd1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("mid_rst_idle", {62'd0, rsp_valid, req_ready}, 64'b01);
      repeat (LAT + 1) @(negedge clk);
      chk("mid_rst_norsp", 64'(rsp_valid), 64'd0);
      txn("mid_rst_ld40", 1'b0, 64'd40, 64'd0, 4'd1, 64'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
